cordic_pol2cart_iter: RTL

CORDIC_POL2CART_ITER -- requirements
Module: cordic_pol2cart_iter

---
 rtl/cordic_pol2cart_iter_if.sv | 13 +
 rtl/cordic_pol2cart_iter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cordic_pol2cart_iter_if.sv
// Conversion request (start/r/theta) and result (ready/done/x/y) bundle for cordic_pol2cart_iter.
interface cordic_pol2cart_iter_if;
  logic               start;
  logic signed [15:0] r;
  logic signed [15:0] theta;
  logic               ready;
  logic               done;
  logic signed [15:0] x;
  logic signed [15:0] y;

  modport master (output start, r, theta, input ready, done, x, y);
  modport slave  (input start, r, theta, output ready, done, x, y);
endinterface

// File: rtl/cordic_pol2cart_iter.sv
// Iterative CORDIC polar->cartesian, Q3.12; CORDIC_GAIN_COMP_EN adds a 2-stage 0.60725 gain multiply.
// Latency NUM_ITER+1 edges (NUM_ITER+3 with gain comp) from accept; ce low stalls everything, ready only in IDLE.
module cordic_pol2cart_iter #(
  parameter int NUM_ITER = 12
) (
  input logic                   clk,
  input logic                   reset,
  input logic                   ce,
  cordic_pol2cart_iter_if.slave bus
);

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ROTATE, SCALE} state_t;
  localparam logic signed [29:0] GAIN = 30'sd2487;
  logic signed [17:0] op_x, op_y;
  logic signed [29:0] prod_x, prod_y;
  logic               sc_ph;
`else
  typedef enum logic [1:0] {IDLE, ROTATE} state_t;
`endif

  localparam logic signed [17:0] PI_Q   = 18'sd12868;
  localparam logic signed [17:0] HALF_PI = 18'sd6434;
  localparam logic [3:0]         LAST   = 4'(NUM_ITER);

  state_t             state;
  logic [3:0]         cnt;
  logic signed [17:0] x_q, y_q, z_q;
  logic signed [17:0] x_n, y_n, z_n, x_sh, y_sh, at;
  logic signed [17:0] th_in, th_sat, r_ext, px, py, pz;

  function automatic logic signed [17:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:  return 18'sd3217;
      4'd1:  return 18'sd1899;
      4'd2:  return 18'sd1003;
      4'd3:  return 18'sd509;
      4'd4:  return 18'sd256;
      4'd5:  return 18'sd128;
      4'd6:  return 18'sd64;
      4'd7:  return 18'sd32;
      4'd8:  return 18'sd16;
      4'd9:  return 18'sd8;
      4'd10: return 18'sd4;
      4'd11: return 18'sd2;
      default: return 18'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7fff;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // Quadrant pre-rotation brings the angle into the CORDIC convergence range.
  always_comb begin
    th_in = 18'(bus.theta);
    r_ext = 18'(bus.r);
    if (th_in > PI_Q)       th_sat = PI_Q;
    else if (th_in < -PI_Q) th_sat = -PI_Q;
    else                    th_sat = th_in;
    if (th_sat > HALF_PI) begin
      px = '0;     py = r_ext;  pz = th_sat - HALF_PI;
    end else if (th_sat < -HALF_PI) begin
      px = '0;     py = -r_ext; pz = th_sat + HALF_PI;
    end else begin
      px = r_ext;  py = '0;     pz = th_sat;
    end
  end

  always_comb begin
    x_sh = x_q >>> cnt;
    y_sh = y_q >>> cnt;
    at   = atan_lut(cnt);
    if (!z_q[17]) begin
      x_n = x_q - y_sh;  y_n = y_q + x_sh;  z_n = z_q - at;
    end else begin
      x_n = x_q + y_sh;  y_n = y_q - x_sh;  z_n = z_q + at;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bus.ready <= 1'b1;
      bus.done  <= 1'b0;
      bus.x     <= '0;
      bus.y     <= '0;
      cnt       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
`ifdef CORDIC_GAIN_COMP_EN
      op_x      <= '0;
      op_y      <= '0;
      prod_x    <= '0;
      prod_y    <= '0;
      sc_ph     <= 1'b0;
`endif
    end else if (ce) begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          x_q       <= px;
          y_q       <= py;
          z_q       <= pz;
          cnt       <= '0;
          state     <= ROTATE;
          bus.ready <= 1'b0;
        end
        ROTATE: if (cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          op_x  <= x_q;
          op_y  <= y_q;
          sc_ph <= 1'b0;
          state <= SCALE;
`else
          bus.x     <= sat16(32'(x_q));
          bus.y     <= sat16(32'(y_q));
          bus.done  <= 1'b1;
          bus.ready <= 1'b1;
          state     <= IDLE;
`endif
        end else begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          cnt <= cnt + 4'd1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: if (!sc_ph) begin
          prod_x <= 30'(op_x) * GAIN;
          prod_y <= 30'(op_y) * GAIN;
          sc_ph  <= 1'b1;
        end else begin
          bus.x     <= sat16(32'(prod_x >>> 12));
          bus.y     <= sat16(32'(prod_y >>> 12));
          bus.done  <= 1'b1;
          bus.ready <= 1'b1;
          sc_ph     <= 1'b0;
          state     <= IDLE;
        end
`endif
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
